// File: rtl/switch4_sched.sv
// Four-lane scheduler for a two-stage XOR-permutation network.
// Each round picks the network configuration serving the most requesters, with an age-based starvation override.

module switch4_sched_lane #(
  parameter int LANE       = 0,
  parameter int STARVE_LIM = 7,
  parameter int AGE_W      = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic [1:0]       dst,
  input  logic             age_upd,
  input  logic             granted,
  output logic [3:0]       svc,
  output logic             starved,
  output logic [AGE_W-1:0] age
);
  localparam logic [1:0]       ID  = 2'(LANE);
  localparam logic [AGE_W-1:0] LIM = AGE_W'(STARVE_LIM);

  // svc[k]: this lane is requesting and is routed correctly by configuration k
  always_comb begin
    svc = '0;
    for (int k = 0; k < 4; k++)
      svc[k] = req && (dst == (ID ^ 2'(k)));
  end

  assign starved = req && (age == LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          age <= '0;
    else if (!req)       age <= '0;
    else if (age_upd) begin
      if (granted)       age <= '0;
      else if (age < LIM) age <= age + 1'b1;
    end
  end
endmodule

module switch4_sched #(
  parameter int STARVE_LIM = 7,
  parameter int AGE_W      = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [1:0] dst0,
  input  logic [1:0] dst1,
  input  logic [1:0] dst2,
  input  logic [1:0] dst3,
  output logic       sel0,
  output logic       sel1,
  output logic [3:0] gnt,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, SETUP, XFER} state_t;

  state_t                 state, state_n;
  logic [1:0]             sel, rr_ptr, best_k, force_k, chosen, kk;
  logic [3:0]             mask, mask_n, starved;
  logic [3:0][1:0]        dst;
  logic [3:0][3:0]        svc;
  logic [3:0][2:0]        cnt;
  logic [2:0]             best_cnt;
  logic [3:0][AGE_W-1:0]  age;
  logic                   decide, any_starved;

  assign dst    = {dst3, dst2, dst1, dst0};
  assign decide = (state == IDLE) && (req != 4'b0);
  assign busy   = (state != IDLE);
  assign sel0   = sel[1];
  assign sel1   = sel[0];

  for (genvar i = 0; i < 4; i++) begin : g_lane
    switch4_sched_lane #(.LANE(i), .STARVE_LIM(STARVE_LIM), .AGE_W(AGE_W)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req[i]),
      .dst     (dst[i]),
      .age_upd (state == XFER),
      .granted (gnt[i]),
      .svc     (svc[i]),
      .starved (starved[i]),
      .age     (age[i])
    );
  end

  always_comb begin
    cnt = '0;
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 4; i++)
        cnt[k] = cnt[k] + 3'(svc[i][k]);
  end

  // Strict '>' keeps the first maximum found when scanning up from rr_ptr
  always_comb begin
    best_k   = rr_ptr;
    best_cnt = cnt[rr_ptr];
    kk       = rr_ptr;
    for (int off = 1; off < 4; off++) begin
      kk = rr_ptr + 2'(off);
      if (cnt[kk] > best_cnt) begin
        best_k   = kk;
        best_cnt = cnt[kk];
      end
    end
  end

  // Downward scan so the lowest starved lane wins
  always_comb begin
    force_k = '0;
    for (int i = 3; i >= 0; i--)
      if (starved[i]) force_k = 2'(i) ^ dst[i];
  end

  assign any_starved = |starved;
  assign chosen      = any_starved ? force_k : best_k;

  always_comb begin
    mask_n = '0;
    for (int i = 0; i < 4; i++)
      mask_n[i] = svc[i][chosen];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (decide) state_n = (chosen == sel) ? XFER : SETUP;
      SETUP:   state_n = XFER;
      XFER:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // gnt is loaded on the edge entering XFER so it is high for exactly that cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel    <= '0;
      rr_ptr <= '0;
      mask   <= '0;
      gnt    <= '0;
    end else begin
      gnt <= '0;
      if (decide) begin
        mask   <= mask_n;
        rr_ptr <= chosen + 2'd1;
        if (chosen != sel) sel <= chosen;
        else               gnt <= mask_n;
      end
      if (state == SETUP) gnt <= mask;
    end
  end
endmodule

// File: tb/tb_switch4_sched.sv
// Directed bench for switch4_sched: cycle vector table plus reset-abort and starvation sequences.

module tb_switch4_sched;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [7:0] dstv;
  logic       sel0, sel1, busy;
  logic [3:0] gnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  switch4_sched dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .dst0 (dstv[1:0]),
    .dst1 (dstv[3:2]),
    .dst2 (dstv[5:4]),
    .dst3 (dstv[7:6]),
    .sel0 (sel0),
    .sel1 (sel1),
    .gnt  (gnt),
    .busy (busy)
  );

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic [7:0] dst;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
  } vec_t;

  vec_t vec [17];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] outs();
    return 16'({gnt, sel0, sel1, busy});
  endfunction

  task automatic wait_gnt(output logic ok);
    ok = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (gnt != 4'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    logic ok;
    // rst, req, dst{3,2,1,0}, gnt, {sel0,sel1}, busy -- expected after the edge
    vec[0]  = '{1'b0, 4'h0, 8'h00, 4'h0, 2'b00, 1'b0};
    vec[1]  = '{1'b1, 4'h0, 8'h00, 4'h0, 2'b00, 1'b0};
    vec[2]  = '{1'b1, 4'h1, 8'h00, 4'h1, 2'b00, 1'b1};
    vec[3]  = '{1'b1, 4'h0, 8'h00, 4'h0, 2'b00, 1'b0};
    vec[4]  = '{1'b1, 4'h0, 8'h00, 4'h0, 2'b00, 1'b0};
    vec[5]  = '{1'b1, 4'hF, 8'h1B, 4'h0, 2'b11, 1'b1};
    vec[6]  = '{1'b1, 4'hF, 8'h1B, 4'hF, 2'b11, 1'b1};
    vec[7]  = '{1'b1, 4'h0, 8'h1B, 4'h0, 2'b11, 1'b0};
    vec[8]  = '{1'b0, 4'h0, 8'h00, 4'h0, 2'b00, 1'b0};
    vec[9]  = '{1'b1, 4'h3, 8'h0C, 4'h1, 2'b00, 1'b1};
    vec[10] = '{1'b1, 4'h3, 8'h0C, 4'h0, 2'b00, 1'b0};
    vec[11] = '{1'b1, 4'h3, 8'h0C, 4'h0, 2'b10, 1'b1};
    vec[12] = '{1'b1, 4'h3, 8'h0C, 4'h2, 2'b10, 1'b1};
    vec[13] = '{1'b1, 4'h0, 8'h00, 4'h0, 2'b10, 1'b0};
    vec[14] = '{1'b1, 4'hF, 8'h1B, 4'h0, 2'b11, 1'b1};
    vec[15] = '{1'b1, 4'h0, 8'h1B, 4'hF, 2'b11, 1'b1};
    vec[16] = '{1'b1, 4'h0, 8'h00, 4'h0, 2'b11, 1'b0};

    rst_n = 1'b0; req = '0; dstv = '0;

    for (int v = 0; v < 17; v++) begin
      @(negedge clk);
      rst_n = vec[v].rst_n; req = vec[v].req; dstv = vec[v].dst;
      @(posedge clk); #1;
      check($sformatf("vec%0d gnt/sel/busy", v), outs(),
            16'({vec[v].gnt, vec[v].sel, vec[v].busy}));
    end
    check("ages after req drop", 16'(dut.age), 16'h0000);

    // Reset while in SETUP after a k=3 decision
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1; req = 4'hF; dstv = 8'h1B;
    @(posedge clk); #1;
    check("setup k=3 entered", outs(), 16'({4'h0, 2'b11, 1'b1}));
    #2 rst_n = 1'b0;
    #1 check("async reset in setup", outs(), 16'h0000);
    @(negedge clk); rst_n = 1'b1; req = 4'h0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check($sformatf("no grant after abort c%0d", c), outs(), 16'h0000);
    end

    // Starvation: lanes 0-2 want k=1, lane 3 wants k=0
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1; req = 4'hF; dstv = 8'hF1;
    for (int r = 1; r <= 16; r++) begin
      wait_gnt(ok);
      if (!ok) begin
        n_tests++; n_fail++;
        $display("FAIL starve round %0d: no gnt within bound, expected %h", r, (r % 8 == 0) ? 4'h8 : 4'h7);
        break;
      end
      check($sformatf("starve round %0d gnt", r), 16'(gnt), (r % 8 == 0) ? 16'h8 : 16'h7);
      if (r == 8) begin
        @(posedge clk); #1;
        check("ages after forced round", 16'(dut.age), 16'({3'd0, 3'd1, 3'd1, 3'd1}));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/switch4_sched.md
SWITCH4_SCHED -- requirements
Module: switch4_sched

Interface
REQ-001 The module SHALL have parameter STARVE_LIM, default 7, meaning the number of lost arbitration rounds after which a lane is force-served.
REQ-002 The module SHALL have parameter AGE_W, default 3, meaning the width of each per-lane age counter; STARVE_LIM SHALL fit in AGE_W bits.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  4  req[i] high = input lane i requests a transfer.
REQ-006 dst0, dst1, dst2, dst3  input  2 each  destination output port of lane i; valid while req[i] is high.
REQ-007 sel0  output  1  registered first-stage select for the downstream 4x4 network.
REQ-008 sel1  output  1  registered second-stage select for the downstream 4x4 network.
REQ-009 gnt  output  4  registered one-cycle grant pulse per lane.
REQ-010 busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-011 Network model: with configuration k = {sel0, sel1} (sel0 = k[1], sel1 = k[0]), output j carries input j XOR k; lane i is servable under k iff dst_i == i XOR k.
REQ-012 The FSM SHALL have states IDLE, SETUP and XFER.
REQ-013 IDLE with req == 0: remain in IDLE; no state change other than the ages (REQ-020).
REQ-014 IDLE with req != 0: compute count(k) = number of lanes with req[i] high and dst_i == i XOR k, for k = 0..3.
REQ-015 Normal choice: pick the k with maximum count; on a tie, pick the first k found scanning upward from rr_ptr, mod 4.
REQ-016 Starvation override: if any requesting lane has age == STARVE_LIM, pick k = i XOR dst_i for the lowest such i; this takes precedence over REQ-015.
REQ-017 At the decision edge:
- latch grant mask = all requesting lanes servable under the chosen k;
- set rr_ptr <= chosen k + 1, mod 4.
REQ-018 Next state from the decision edge:
- chosen k == current {sel0, sel1}: go to XFER, sels unchanged;
- otherwise: load sel0/sel1 with the chosen k at that same edge and go to SETUP.
REQ-019 SETUP SHALL last exactly one cycle with gnt = 0, then go to XFER; XFER SHALL drive gnt = latched mask for exactly one cycle, then return to IDLE.
REQ-020 Age counters, updated at the XFER-exit edge:
- lanes with req high and not granted: increment, saturating at STARVE_LIM;
- granted lanes: clear to 0.
REQ-021 Any lane whose req is low at any edge SHALL have its age cleared.
REQ-022 Latency from the IDLE decision edge to gnt high:
- 1 cycle without reconfiguration;
- 2 cycles with reconfiguration.
REQ-023 A requester SHALL hold req and dst stable until its gnt pulse.
REQ-024 A request dropped before its grant SHALL still have its latched gnt bit pulse; the requester ignores it.
REQ-025 sel0/sel1 SHALL change only at a decision edge that leads to SETUP, never while in XFER.
REQ-026 gnt SHALL be 0 in IDLE and SETUP; gnt bits SHALL be set only for lanes servable under the current {sel0, sel1}.

Reset
REQ-027 While rst_n is low, immediately and independent of clk:
- state = IDLE, rr_ptr = 0, all ages = 0;
- sel0 = 0, sel1 = 0, gnt = 0000, busy = 0.
REQ-028 Reset asserted in SETUP or XFER SHALL abort the round with no gnt pulse; after release, the FSM SHALL start from IDLE.

Verification
REQ-029 Directed scenarios the bench SHALL cover:
- After reset, req=0001, dst0=0 -> k=0, no SETUP; gnt=0001 for one cycle, one cycle after the decision edge; busy high for 1 cycle.
- req=1111, dst_i = i XOR 3 (dst0=3, dst1=2, dst2=1, dst3=0) -> sel0=1, sel1=1 after the decision edge; one SETUP cycle with gnt=0000; then gnt=1111.
- From reset, req=0011 held, dst0=0, dst1=3 -> count(0)=count(2)=1; first round k=0, gnt=0001; second round k=2, SETUP, gnt=0010.
- Starvation: lanes 0-2 always requesting with dst_i = i XOR 1, lane 3 with dst3=3; lane 3 loses 7 rounds, then the 8th round forces k=0 with gnt=1000; its age returns to 0.
- rst_n pulsed low while in SETUP after a k=3 decision -> sel0=sel1=0, busy=0 and gnt=0000 immediately; no grant pulse follows release until a new request.
- req changes to 0000 during SETUP -> the XFER gnt pulse still matches the latched mask; all ages = 0 afterwards.
